circuit_sweep_ctrl: RTL and testbench
=====================================

// Module: circuit_sweep_ctrl
// PURPOSE
//  Sequencer for the `circuit` block (8:1 mux, select {a,b,c}, data derived from d,e).
//  On start it drives all 32 input vectors {a,b,c,d,e} in order and waits a settle
//  interval for each one. It then samples y and assembles a 32-bit truth table.
//  Sits between the test/config logic and `circuit`; the circuit stays combinational.
// PARAMETERS
//  SETTLE_CYCLES  1  extra cycles each vector is held before y is sampled (0..15)
//  CNT_W          4  width of the settle counter; must hold SETTLE_CYCLES
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  start        in   1   begin a sweep; accepted only in IDLE
//  abort        in   1   synchronous cancel of a running sweep
//  sel_o        out  3   to circuit {a,b,c}; sel_o[2]=a (MSB)
//  d_o          out  1   to circuit d
//  e_o          out  1   to circuit e
//  y_i          in   1   from circuit y
//  busy         out  1   high in DRIVE/SAMPLE
//  done         out  1   one-cycle pulse when the table is complete
//  table_o      out  32  truth table; bit idx = y for idx={a,b,c,d,e}
//  table_valid  out  1   table_o holds a complete sweep
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, idx=0, cnt=0, sel_o=0, d_o=0, e_o=0, busy=0,
//    done=0, table_o=0, table_valid=0. Reset mid-sweep discards all partial results.
//  - Vector index: idx[4:0]. Output drive: {sel_o,d_o,e_o}=idx, registered, and held
//    stable for the whole of DRIVE and SAMPLE.
//  - FSM states: IDLE, DRIVE, SAMPLE, DONE.
//    IDLE:   start=1 -> DRIVE. On that edge: idx=0, cnt=SETTLE_CYCLES, table_valid=0,
//            table_o=0. start=0 -> stay in IDLE. abort is ignored in IDLE.
//    DRIVE:  abort=1 -> IDLE. Else cnt!=0 -> cnt--; cnt==0 -> SAMPLE.
//            DRIVE lasts SETTLE_CYCLES+1 cycles.
//    SAMPLE: table_o[idx] <= y_i, even when abort is high on the same edge.
//            Then, with abort=1 -> IDLE (table_valid stays 0).
//            idx==31 -> DONE; else idx++, cnt=SETTLE_CYCLES -> DRIVE.
//    DONE:   done=1 and table_valid<=1 for exactly one cycle, then IDLE.
//            start is not accepted in DONE.
//  - start while busy or in DONE is ignored; it is not queued.
//  - table_o is written only bit-wise in SAMPLE. It holds its value across IDLE until
//    the next accepted start clears it. After an abort it holds partial bits with
//    table_valid=0.
//  - idx never wraps: its increment is suppressed at 31.
//  - Latency: done is high in the cycle after 32*(SETTLE_CYCLES+2) clock edges
//    following the accepting edge. With default settings done rises on edge 97,
//    counting the start-accept edge as 0.
//  - busy = (state==DRIVE || state==SAMPLE); combinational decode of registered state.
// TESTING
//  1. Reset held, then released -> all outputs 0, state IDLE; no activity without start.
//  2. start pulse, SETTLE=1, y_i from a real `circuit` instance -> done on edge 97,
//     table_o=32'hB32D224C, table_valid=1.
//  3. y_i tied 1 and SETTLE=0 -> done after 64+1 edges, table_o=32'hFFFFFFFF.
//     A second start while busy changes nothing.
//  4. abort raised during DRIVE of idx=5 -> IDLE next edge, busy=0, table_valid=0,
//     table_o[4:0] keeps the sampled bits. A new start clears table_o and restarts at idx 0.
//  5. rst_n pulsed low mid-sweep at idx=17 -> outputs 0 immediately, asynchronously.
//     After release, start runs a full clean sweep that matches scenario 2.
//  6. Vector order check: for each SAMPLE, {sel_o,d_o,e_o} == idx; it is stable for
//     SETTLE+2 cycles and steps 0..31 with no skips or repeats.

Source files
------------

// File: rtl/circuit_sweep_ctrl.sv
// circuit_sweep_ctrl: steps all 32 {a,b,c,d,e} vectors through `circuit`, lets each settle,
// samples y and assembles the 32-bit truth table.
module circuit_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [2:0]  sel_o,
  output logic        d_o,
  output logic        e_o,
  input  logic        y_i,
  output logic        busy,
  output logic        done,
  output logic [31:0] table_o,
  output logic        table_valid
);
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  state_t state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] table_q, table_d;
  logic valid_q, valid_d, done_q, done_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      table_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    table_d = table_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = DRIVE;
        idx_d   = '0;
        cnt_d   = CNT_W'(SETTLE_CYCLES);
        table_d = '0;
        valid_d = 1'b0;
      end
      DRIVE: begin
        if (abort) state_d = IDLE;
        else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else state_d = SAMPLE;
      end
      SAMPLE: begin
        // The bit is captured even on an aborting edge
        table_d[idx_q] = y_i;
        if (abort) state_d = IDLE;
        else if (idx_q == 5'd31) state_d = DONE;
        else begin
          idx_d   = idx_q + 5'd1;
          cnt_d   = CNT_W'(SETTLE_CYCLES);
          state_d = DRIVE;
        end
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b1;
        valid_d = 1'b1;
      end
    endcase
  end
  assign {sel_o, d_o, e_o} = idx_q;
  assign busy        = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done        = done_q;
  assign table_o     = table_q;
  assign table_valid = valid_q;
endmodule

// File: tb/tb_circuit_sweep_ctrl.sv
// tb_circuit_sweep_ctrl: two controllers (settle 0 and 1) driving a lookup-table model of
// `circuit`; results checked against expected truth tables, vector order and latency.
module tb_circuit_sweep_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start [2];
  logic abort [2];
  logic y [2];
  logic [2:0] sel [2];
  logic d [2];
  logic e [2];
  logic busy [2];
  logic done [2];
  logic valid [2];
  logic [31:0] tbl [2];
  logic [31:0] tt [2];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // The circuit is modelled as its own truth table indexed by {a,b,c,d,e}
  assign y[0] = tt[0][{sel[0], d[0], e[0]}];
  assign y[1] = tt[1][{sel[1], d[1], e[1]}];

  circuit_sweep_ctrl #(.SETTLE_CYCLES(0), .CNT_W(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .sel_o(sel[0]), .d_o(d[0]), .e_o(e[0]), .y_i(y[0]),
    .busy(busy[0]), .done(done[0]), .table_o(tbl[0]), .table_valid(valid[0]));

  circuit_sweep_ctrl #(.SETTLE_CYCLES(1), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .sel_o(sel[1]), .d_o(d[1]), .e_o(e[1]), .y_i(y[1]),
    .busy(busy[1]), .done(done[1]), .table_o(tbl[1]), .table_valid(valid[1]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      start[s] = 1'b0;
      abort[s] = 1'b0;
      tt[s] = 32'h0;
    end
    #3;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if ({sel[s], d[s], e[s], busy[s], done[s], valid[s], tbl[s]} !== 40'h0) begin
        errors++;
        $display("FAIL reset_held s=%0d got vec=%0d busy=%b done=%b valid=%b table=%h exp all 0",
                 s, {sel[s], d[s], e[s]}, busy[s], done[s], valid[s], tbl[s]);
      end
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    for (int s = 0; s < 2; s++) begin
      checks++;
      if ({sel[s], d[s], e[s], busy[s], done[s], valid[s], tbl[s]} !== 40'h0) begin
        errors++;
        $display("FAIL reset_idle s=%0d got vec=%0d busy=%b done=%b valid=%b table=%h exp all 0",
                 s, {sel[s], d[s], e[s]}, busy[s], done[s], valid[s], tbl[s]);
      end
    end
  endtask

  // Full sweep: table, latency 32*(s+2)+1, vector run lengths, ignored starts
  task automatic test_sweep(input int s, input logic [31:0] t, input bit extra_start);
    logic [4:0] vq[$];
    int n = 0;
    int lat = 32 * (s + 2) + 1;
    tt[s] = t;
    tick();
    start[s] = 1'b1;
    tick();
    start[s] = 1'b0;
    checks++;
    if (busy[s] !== 1'b1 || valid[s] !== 1'b0 || tbl[s] !== 32'h0 || {sel[s], d[s], e[s]} !== 5'd0) begin
      errors++;
      $display("FAIL accept s=%0d got busy=%b valid=%b table=%h vec=%0d exp 1 0 0 0",
               s, busy[s], valid[s], tbl[s], {sel[s], d[s], e[s]});
    end
    while (done[s] !== 1'b1 && n < 400) begin
      if (busy[s] === 1'b1) vq.push_back({sel[s], d[s], e[s]});
      start[s] = extra_start && (n == 10 || n == lat - 1);
      tick();
      n++;
    end
    start[s] = 1'b0;
    checks++;
    if (n !== lat) begin
      errors++;
      $display("FAIL latency s=%0d got %0d exp %0d", s, n, lat);
    end
    checks++;
    if (tbl[s] !== t || valid[s] !== 1'b1 || busy[s] !== 1'b0) begin
      errors++;
      $display("FAIL result s=%0d got table=%h valid=%b busy=%b exp table=%h valid=1 busy=0",
               s, tbl[s], valid[s], busy[s], t);
    end
    checks++;
    if (vq.size() !== 32 * (s + 2)) begin
      errors++;
      $display("FAIL busy_len s=%0d got %0d exp %0d", s, vq.size(), 32 * (s + 2));
    end
    for (int k = 0; k < vq.size(); k++) begin
      checks++;
      if (vq[k] !== 5'(k / (s + 2))) begin
        errors++;
        $display("FAIL vec_order s=%0d cycle=%0d got %0d exp %0d", s, k, vq[k], k / (s + 2));
      end
    end
    tick();
    checks++;
    if (done[s] !== 1'b0 || valid[s] !== 1'b1 || busy[s] !== 1'b0 || tbl[s] !== t) begin
      errors++;
      $display("FAIL after_done s=%0d got done=%b valid=%b busy=%b table=%h exp 0 1 0 %h",
               s, done[s], valid[s], busy[s], tbl[s], t);
    end
  endtask

  task automatic wait_vec(input int s, input logic [4:0] v);
    int n = 0;
    while ({sel[s], d[s], e[s]} !== v && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL wait_vec s=%0d timeout got %0d exp %0d", s, {sel[s], d[s], e[s]}, v);
    end
  endtask

  task automatic test_abort_drive();
    logic [31:0] t = $urandom;
    tt[1] = t;
    tick();
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    wait_vec(1, 5'd5);
    abort[1] = 1'b1;
    tick();
    abort[1] = 1'b0;
    checks++;
    if (busy[1] !== 1'b0 || valid[1] !== 1'b0 || tbl[1] !== {27'h0, t[4:0]}) begin
      errors++;
      $display("FAIL abort_drive got busy=%b valid=%b table=%h exp 0 0 %h",
               busy[1], valid[1], tbl[1], {27'h0, t[4:0]});
    end
    abort[1] = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    abort[1] = 1'b0;
    checks++;
    if (busy[1] !== 1'b0 || tbl[1] !== {27'h0, t[4:0]}) begin
      errors++;
      $display("FAIL abort_hold got busy=%b table=%h exp 0 %h", busy[1], tbl[1], {27'h0, t[4:0]});
    end
    test_sweep(1, $urandom, 1'b0);
  endtask

  task automatic test_abort_sample();
    logic [31:0] t = $urandom;
    tt[0] = t;
    tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_vec(0, 5'd3);
    tick();
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b0 || valid[0] !== 1'b0 || tbl[0] !== {28'h0, t[3:0]}) begin
      errors++;
      $display("FAIL abort_sample got busy=%b valid=%b table=%h exp 0 0 %h",
               busy[0], valid[0], tbl[0], {28'h0, t[3:0]});
    end
  endtask

  task automatic test_reset_mid();
    tt[1] = 32'hB32D224C;
    tick();
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    wait_vec(1, 5'd17);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sel[1], d[1], e[1], busy[1], done[1], valid[1], tbl[1]} !== 40'h0) begin
      errors++;
      $display("FAIL reset_mid got vec=%0d busy=%b done=%b valid=%b table=%h exp all 0",
               {sel[1], d[1], e[1]}, busy[1], done[1], valid[1], tbl[1]);
    end
    tick();
    rst_n = 1'b1;
    test_sweep(1, 32'hB32D224C, 1'b0);
  endtask

  initial begin
    test_reset();
    test_sweep(1, 32'hB32D224C, 1'b1);
    test_sweep(0, 32'hFFFFFFFF, 1'b1);
    test_abort_drive();
    test_abort_sample();
    test_sweep(0, $urandom, 1'b0);
    test_reset_mid();
    for (int i = 0; i < 3; i++) test_sweep(i % 2, $urandom, i[0]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
